// File: rtl/rr_arbiter.sv
// Four-requester round-robin arbiter with a two-state IDLE/GRANT FSM and registered outputs.
// Optional grant watchdog is compiled in by defining ARB_TIMEOUT_EN.
module rr_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] req,
  input  logic       ack,
  input  logic [7:0] irq,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       done,
  output logic [7:0] irq_q,
  output logic       timeout_err
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [3:0] r_gnt;
  logic [1:0] r_owner;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_irq_q;
  logic [1:0] w_pick;
  logic [1:0] w_idx;
  logic       w_any_req;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_err;
`endif

  // Scan downward so the lowest offset from r_ptr is the last, winning, assignment.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_pick    = r_ptr;
    w_idx     = r_ptr;
    w_any_req = |req;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (req[w_idx]) w_pick = w_idx;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_owner <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_irq_q <= 8'h00;
`ifdef ARB_TIMEOUT_EN
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state <= S_GRANT;
            r_gnt   <= 4'b0001 << w_pick;
            r_owner <= w_pick;
            r_busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (ack) begin
            r_state <= S_IDLE;
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_irq_q <= irq;
            r_ptr   <= r_owner + 2'd1;
          end
`ifdef ARB_TIMEOUT_EN
          // The count equals the number of finished GRANT cycles, so TIMEOUT-1 marks the last one.
          else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state       <= S_IDLE;
            r_gnt         <= 4'b0000;
            r_busy        <= 1'b0;
            r_ptr         <= r_owner + 2'd1;
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign busy  = r_busy;
  assign done  = r_done;
  assign irq_q = r_irq_q;

`ifdef ARB_TIMEOUT_EN
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed scenarios plus random traffic against a cycle model.
// Set ARB_TIMEOUT_EN for both bench and RTL to exercise the watchdog build.
module tb_rr_arbiter;

  localparam int TIMEOUT = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req;
  logic       ack;
  logic [7:0] irq;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       done;
  logic [7:0] irq_q;
  logic       timeout_err;

  rr_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .ack         (ack),
    .irq         (irq),
    .gnt         (gnt),
    .owner       (owner),
    .busy        (busy),
    .done        (done),
    .irq_q       (irq_q),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: who holds the resource, how long, and where the next scan starts.
  bit       m_busy;
  bit       m_done;
  bit       m_to_err;
  int       m_owner;
  int       m_ptr;
  int       m_age;
  bit       m_rst_seen;
  bit [7:0] m_irq_q;

  int dut_grants[$];
  bit prev_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Apply one clock edge's worth of the specified rules to the model.
  task automatic model_edge();
    m_rst_seen = !rstn;
    if (!rstn) begin
      m_busy = 0; m_done = 0; m_to_err = 0;
      m_owner = 0; m_ptr = 0; m_age = 0; m_irq_q = 8'h00;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (req != 4'b0000) begin
          m_owner = rr_pick(m_ptr, req);
          m_busy  = 1;
          m_age   = 0;
        end
      end else begin
        m_age++;
        if (ack) begin
          m_irq_q = irq;
          m_done  = 1;
          m_busy  = 0;
          m_ptr   = (m_owner + 1) % 4;
        end else if (TO_EN && m_age == TIMEOUT) begin
          m_busy   = 0;
          m_to_err = 1;
          m_ptr    = (m_owner + 1) % 4;
        end
      end
    end
  endtask

  task automatic compare();
    check("gnt", gnt, m_busy ? (32'd1 << m_owner) : 32'd0);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("irq_q", irq_q, m_irq_q);
    check("timeout_err", timeout_err, m_to_err);
    if (m_busy || m_rst_seen) check("owner", owner, m_owner);
    if (busy && !prev_busy) dut_grants.push_back(int'(owner));
    prev_busy = busy;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // Wait (bounded) for a grant, hold it for 'hold' cycles, then ack with irqv.
  task automatic do_txn(input logic [3:0] r, input int hold, input logic [7:0] irqv,
                        input bit drop_req, input bit req_after_ack);
    int n;
    req = r; ack = 1'b0;
    n = 0;
    while (!m_busy && n < 8) begin
      step();
      n++;
    end
    check("grant_wait", m_busy, 1'b1);
    if (drop_req) req = 4'b0000;
    repeat (hold) step();
    ack = 1'b1; irq = irqv;
    step();
    ack = 1'b0; irq = 8'h00;
    if (!req_after_ack) req = 4'b0000;
  endtask

  task automatic do_reset(input int cycles);
    rstn = 1'b0;
    repeat (cycles) step();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; req = 4'b0000; ack = 1'b0; irq = 8'h00;
    prev_busy = 1'b0;
    m_busy = 0; m_done = 0; m_to_err = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_irq_q = 0;
    m_rst_seen = 0;

    // Reset state, then a held all-requesters pattern acked two cycles after each grant.
    do_reset(2);
    dut_grants.delete();
    for (int g = 0; g < 5; g++) do_txn(4'b1111, 1, 8'(g + 8'h10), 1'b0, 1'b1);
    req = 4'b0000;
    step();
    check("rr_count", dut_grants.size(), 5);
    for (int g = 0; g < 5 && g < dut_grants.size(); g++)
      check($sformatf("rr_order%0d", g), dut_grants[g], g % 4);

    // Lone requester 2 with irq capture, then a wrap-around pick from pointer 3.
    do_reset(1);
    dut_grants.delete();
    do_txn(4'b0100, 2, 8'hA5, 1'b0, 1'b0);
    step();
    check("irq_capture", irq_q, 8'hA5);
    do_txn(4'b0011, 1, 8'h3C, 1'b0, 1'b0);
    step();
    check("wrap_count", dut_grants.size(), 2);
    if (dut_grants.size() == 2) begin
      check("lone_owner", dut_grants[0], 2);
      check("wrap_owner", dut_grants[1], 0);
    end

    // Granted request dropped before the ack; grant must hold for five cycles.
    do_txn(4'b0010, 5, 8'h77, 1'b1, 1'b0);
    check("drop_done", done, 1'b1);
    step();

    // Reset in the middle of a grant, then the first grant starts scanning at requester 0.
    req = 4'b0100;
    repeat (3) step();
    do_reset(1);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_done", done, 1'b0);
    dut_grants.delete();
    req = 4'b1111;
    step();
    if (dut_grants.size() > 0) check("post_rst_owner", dut_grants[0], 0);
    else check("post_rst_grant", busy, 1'b1);
    ack = 1'b1; step(); ack = 1'b0; req = 4'b0000; step();

    // No ack for a long stretch: watchdog revokes, or the grant persists without it.
    req = 4'b0001;
    repeat (TIMEOUT + 6) step();
    req = 4'b0000;
    check("no_ack_err", timeout_err, TO_EN);
    repeat (TIMEOUT + 2) step();
    if (!TO_EN) begin
      check("persist_busy", busy, 1'b1);
      ack = 1'b1; step(); ack = 1'b0;
    end
    step();

    // Ack in the last permitted GRANT cycle completes normally.
    do_reset(1);
    do_txn(4'b1000, TIMEOUT - 1, 8'h5A, 1'b0, 1'b0);
    check("late_ack_done", done, 1'b1);
    check("late_ack_err", timeout_err, 1'b0);
    step();

    // Random traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      rstn = ($urandom_range(0, 99) != 0);
      req  = 4'($urandom);
      ack  = ($urandom_range(0, 2) == 0);
      irq  = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum GRANT-state cycles without ack; used only when ARB_TIMEOUT_EN is defined.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port rstn, input, 1: synchronous active-low reset.
REQ-005 Port req, input, 4: per-requester request, bit i is requester i.
REQ-006 Port ack, input, 1: shared resource signals that the current transaction is complete.
REQ-007 Port irq, input, 8: resource status, sampled on ack.
REQ-008 Port gnt, output, 4: one-hot grant, registered.
REQ-009 Port owner, output, 2: index of the granted requester; valid while busy=1.
REQ-010 Port busy, output, 1: high in the GRANT state.
REQ-011 Port done, output, 1: one-cycle pulse when a transaction completes.
REQ-012 Port irq_q, output, 8: irq captured at the last completion.
REQ-013 Port timeout_err, output, 1: sticky watchdog flag.

Function
REQ-014 FSM states SHALL be IDLE and GRANT; no other states.
REQ-015 In IDLE with req!=0, the block SHALL select a requester and enter GRANT; gnt goes high on the next edge (request at cycle N -> gnt at N+1).
REQ-016 Selection SHALL be round-robin: the first asserted req bit scanning upward from ptr, wrapping 3->0.
REQ-017 ptr SHALL reset to 0 and on every completion SHALL load owner+1 mod 4.
REQ-018 In GRANT, gnt and owner SHALL hold constant until completion, even if the granted req deasserts.
REQ-019 On ack=1 in GRANT: irq_q<=irq, done=1 for one cycle, gnt<=0, busy<=0, return to IDLE.
REQ-020 After any completion, the block SHALL spend at least one IDLE cycle, so the earliest next grant is two cycles after the ack.
REQ-021 ack in IDLE SHALL be ignored: no done pulse, irq_q unchanged.
REQ-022 gnt SHALL always be zero or one-hot, and gnt!=0 if and only if busy=1.
REQ-023 Requests that change while in GRANT SHALL NOT affect the current grant; they are evaluated in the next IDLE.

Reset
REQ-024 While rstn=0 at a clock edge: gnt=0, owner=0, busy=0, done=0, irq_q=0, timeout_err=0, ptr=0, state=IDLE.
REQ-025 Reset asserted mid-GRANT SHALL abort the transaction with no done pulse; the first grant after reset starts scanning from requester 0.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN SHALL compile the watchdog in or out.
REQ-027 With ARB_TIMEOUT_EN defined: a counter clears on entry to GRANT and increments each GRANT cycle without ack. When it reaches TIMEOUT, the block SHALL revoke the grant (to IDLE), advance ptr as for a completion, set timeout_err=1, leave done=0, and leave irq_q unchanged.
REQ-028 With ARB_TIMEOUT_EN defined: ack in the same cycle the count reaches TIMEOUT SHALL take priority as a normal completion.
REQ-029 With ARB_TIMEOUT_EN defined: timeout_err SHALL clear only on reset.
REQ-030 Without ARB_TIMEOUT_EN: no counter is built, timeout_err is tied 0, and a grant persists indefinitely until ack.

Verification
REQ-031 Scenario: req=4'b1111 held, ack pulsed 2 cycles after each grant -> grant order 0,1,2,3,0; done pulses once per ack.
REQ-032 Scenario: req=4'b0100 only, ack with irq=8'hA5 -> gnt=4'b0100, owner=2, irq_q=8'hA5 after completion, then ptr=3.
REQ-033 Scenario: ptr=3, req=4'b0011 -> gnt=4'b0001 (wrap-around).
REQ-034 Scenario: granted req dropped before ack, ack at +5 cycles -> gnt held until ack, then done=1.
REQ-035 Scenario: rstn low mid-GRANT -> all outputs 0 next edge, no done pulse; next request from requester 0 granted first.
REQ-036 Scenario: with ARB_TIMEOUT_EN and TIMEOUT=16, no ack -> grant dropped after 16 GRANT cycles, timeout_err=1, done=0; ack in the 16th cycle -> normal completion, timeout_err=0.
